// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer on an Avalon-MM slave: each channel has a
// prescaled down-counter, one-shot/continuous modes, a snapshot register and an interrupt.
module multi_interval_timer #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 99999,
  localparam int AW            = (NUM_CH > 1) ? $clog2(NUM_CH) + 2 : 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_e;

  logic        w_wr;
  logic [7:0]  w_ch;
  reg_e        w_reg;
  logic [31:0] w_rd [NUM_CH][4];
  logic [31:0] w_rdata;
  logic [31:0] r_readdata;

  assign w_wr  = chipselect && !write_n;
  assign w_ch  = 8'(address >> 2);
  assign w_reg = reg_e'(address[1:0]);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             r_run, r_to, r_ito, r_cont;
    logic [7:0]       r_prescale, r_pre;
    logic [CNT_W-1:0] r_period, r_cnt, r_snap;
    logic             w_sel, w_tick, w_reload, w_period_wr, w_run_next;

    assign w_sel       = w_wr && (w_ch == 8'(c));
    assign w_period_wr = w_sel && (w_reg == REG_PERIOD);
    assign w_tick      = r_run && (r_pre == r_prescale);
    assign w_reload    = w_tick && (r_cnt == '0);

    // Priority low to high: one-shot expiry, STOP, START, forced reload.
    always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      w_run_next = r_run;
      if (w_reload && !r_cont) w_run_next = 1'b0;
      if (w_sel && (w_reg == REG_CONTROL)) begin
        if (writedata[3]) w_run_next = 1'b0;
        if (writedata[2]) w_run_next = 1'b1;
      end
      if (w_period_wr) w_run_next = 1'b0;
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_run      <= 1'b0;
        r_to       <= 1'b0;
        r_ito      <= 1'b0;
        r_cont     <= 1'b0;
        r_prescale <= '0;
        r_pre      <= '0;
        r_period   <= RST_PERIOD;
        r_cnt      <= RST_PERIOD;
        // NOTE: the snapshot is software-visible, so it is reset like any other register.
        r_snap     <= '0;
      end else begin
        r_run <= w_run_next;

        if (w_run_next && r_run && !w_tick) r_pre <= r_pre + 8'd1;
        else                                r_pre <= '0;

        if (w_period_wr) begin
          r_period <= writedata[CNT_W-1:0];
          r_cnt    <= writedata[CNT_W-1:0];
        end else if (w_tick) begin
          r_cnt <= w_reload ? r_period : r_cnt - CNT_W'(1);
        end

        if (w_sel && (w_reg == REG_STATUS)) r_to <= 1'b0;
        else if (w_reload && !w_period_wr)  r_to <= 1'b1;

        if (w_sel && (w_reg == REG_CONTROL)) begin
          r_ito      <= writedata[0];
          r_cont     <= writedata[1];
          r_prescale <= writedata[15:8];
        end

        if (w_sel && (w_reg == REG_SNAP)) r_snap <= r_cnt;
      end
    end

    assign w_rd[c][0] = {30'b0, r_run, r_to};
    assign w_rd[c][1] = {16'b0, r_prescale, 6'b0, r_cont, r_ito};
    assign w_rd[c][2] = 32'(r_period);
    assign w_rd[c][3] = 32'(r_snap);
    assign irq_vec[c] = r_to && r_ito;
  end

  // Channels at or beyond NUM_CH fall through to zero.
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == 8'(c)) w_rdata = w_rd[c][address[1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdata;
  end

  assign readdata = r_readdata;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// bus traffic compared every cycle against a per-channel behavioural model.
module tb_multi_interval_timer;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic [NCH-1:0] irq_vec;
  logic        irq;

  logic [1:0]  a2;
  logic        cs2, wn2;
  logic [31:0] wd2, rd2;
  logic [0:0]  irqv2;
  logic        irq2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  multi_interval_timer #(.NUM_CH(NCH), .CNT_W(32), .DEFAULT_PERIOD(99999)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq)
  );

  multi_interval_timer #(.NUM_CH(1), .CNT_W(16), .DEFAULT_PERIOD(99999)) dut16 (
    .clk(clk), .reset_n(reset_n), .address(a2), .chipselect(cs2),
    .write_n(wn2), .writedata(wd2), .readdata(rd2),
    .irq_vec(irqv2), .irq(irq2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one record per channel, advanced once per clock by the rules.
  typedef struct {
    bit run, to, ito, cont;
    int unsigned pre, prescale, period, cnt, snap;
  } chan_t;

  chan_t       m [NCH];
  logic [31:0] exp_rdata;

  function automatic logic [31:0] model_read(int unsigned a);
    int unsigned c;
    c = a / 4;
    if (c >= NCH) return 32'd0;
    case (a % 4)
      0:       return {30'b0, m[c].run, m[c].to};
      1:       return 32'(m[c].prescale * 256 + (m[c].cont ? 2 : 0) + (m[c].ito ? 1 : 0));
      2:       return m[c].period;
      default: return m[c].snap;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    chan_t       o, n;
    bit          wr, tick;
    int unsigned a;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m[c] = '{default: 0};
        m[c].period = 99999;
        m[c].cnt    = 99999;
      end
      exp_rdata = 32'd0;
    end else begin
      a  = address;
      wr = chipselect && !write_n;
      exp_rdata = model_read(a);
      for (int c = 0; c < NCH; c++) begin
        o = m[c];
        n = o;
        tick  = o.run && (o.pre == o.prescale);
        n.pre = (o.run && !tick) ? o.pre + 1 : 0;
        if (tick) begin
          if (o.cnt == 0) begin
            n.cnt = o.period;
            n.to  = 1;
            if (!o.cont) n.run = 0;
          end else begin
            n.cnt = o.cnt - 1;
          end
        end
        if (wr && (a / 4 == c)) begin
          case (a % 4)
            0: n.to = 0;
            1: begin
              n.ito = writedata[0];
              n.cont = writedata[1];
              n.prescale = writedata[15:8];
              if (writedata[3]) n.run = 0;
              if (writedata[2]) n.run = 1;
            end
            2: begin
              n.period = writedata;
              n.cnt    = writedata;
              n.run    = 0;
              n.to     = o.to;
            end
            default: n.snap = o.cnt;
          endcase
        end
        if (!n.run) n.pre = 0;
        m[c] = n;
      end
    end
  end

  // Every cycle: readdata and interrupts must match the model.
  always @(negedge clk) begin
    logic [NCH-1:0] ev;
    for (int c = 0; c < NCH; c++) ev[c] = m[c].to && m[c].ito;
    check("readdata", readdata, exp_rdata);
    check("irq_vec", 32'(irq_vec), 32'(ev));
    check("irq", 32'(irq), 32'(|ev));
  end

  // Bus helpers; all are entered just after a falling edge.
  task automatic write_reg(input int a, input logic [31:0] d);
    address = 4'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_reg(input int a, output logic [31:0] d);
    address = 4'(a);
    @(negedge clk);
    d = readdata;
  endtask

  task automatic wait_irq(input int ch, input int start, output int n);
    n = start;
    while (!irq_vec[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int n;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    a2 = 2'd2; cs2 = 1'b0; wn2 = 1'b1; wd2 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset values, including unused channel 3.
    for (int a = 0; a < 16; a++) begin
      read_reg(a, d);
      check($sformatf("reset_reg%0d", a), d, ((a % 4 == 2) && (a < 12)) ? 32'd99999 : 32'd0);
    end
    check("reset_irq", 32'(irq), 32'd0);
    check("w16_default", rd2, 32'h869F);
    wd2 = 32'h12345; cs2 = 1'b1; wn2 = 1'b0;
    @(negedge clk);
    cs2 = 1'b0; wn2 = 1'b1;
    @(negedge clk);
    check("w16_trunc", rd2, 32'h2345);

    // Ch0 continuous, period 9.
    write_reg(2, 32'd9);
    write_reg(1, 32'h7);
    wait_irq(0, 0, n);
    check("ch0_first_to", n, 10);
    write_reg(0, 32'd0);
    check("ch0_cleared", 32'(irq_vec[0]), 32'd0);
    wait_irq(0, 1, n);
    check("ch0_second_to", n, 10);

    // Ch1 one-shot, period 4, prescale 3.
    write_reg(6, 32'd4);
    write_reg(5, 32'h0305);
    wait_irq(1, 0, n);
    check("ch1_oneshot_to", n, 20);
    repeat (30) @(negedge clk);
    read_reg(4, d);
    check("ch1_status", d, 32'd1);
    write_reg(7, 32'd0);
    read_reg(7, d);
    check("ch1_holds", d, 32'd4);
    write_reg(4, 32'd0);
    repeat (30) @(negedge clk);
    check("ch1_no_refire", 32'(irq_vec[1]), 32'd0);

    // Ch0 forced reload mid-count, then restart at period 2.
    write_reg(2, 32'd2);
    write_reg(0, 32'd0);
    read_reg(0, d);
    check("ch0_reload_status", d, 32'd0);
    read_reg(1, d);
    check("ch0_control", d, 32'h3);
    write_reg(3, 32'd0);
    read_reg(3, d);
    check("ch0_reload_cnt", d, 32'd2);
    write_reg(1, 32'h7);
    wait_irq(0, 0, n);
    check("ch0_p2_first", n, 3);
    write_reg(0, 32'd0);
    wait_irq(0, 1, n);
    check("ch0_p2_second", n, 3);

    // Snapshot on a tick edge captures the pre-decrement count.
    write_reg(3, 32'd0);
    read_reg(3, d);
    check("snap_on_tick", d, 32'd2);

    // STATUS clear colliding with a timeout edge.
    write_reg(0, 32'd0);
    wait_irq(0, 0, n);
    repeat (2) @(negedge clk);
    write_reg(0, 32'd0);
    check("clear_wins", 32'(irq_vec[0]), 32'd0);
    read_reg(0, d);
    check("clear_wins_status", d, 32'd2);

    // START and STOP together.
    write_reg(9, 32'hC);
    read_reg(8, d);
    check("start_stop", d, 32'd2);

    // Asynchronous reset with an interrupt pending.
    write_reg(0, 32'd0);
    wait_irq(0, 0, n);
    check("pre_reset_irq", 32'(irq), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'd0);
    check("async_irq_vec", 32'(irq_vec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(2, d);
    check("post_reset_period", d, 32'd99999);
    read_reg(1, d);
    check("post_reset_control", d, 32'd0);
    read_reg(0, d);
    check("post_reset_status", d, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int unsigned a;
      a = $urandom_range(0, 15);
      address    = 4'(a);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      case (a % 4)
        1:       writedata = ($urandom & 32'hFFFF_00F0) | ($urandom_range(0, 2) << 8) | $urandom_range(0, 15);
        2:       writedata = $urandom_range(0, 6);
        default: writedata = $urandom;
      endcase
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
